soc_int_trigger_conditioner: RTL and testbench
==============================================

# soc_int_trigger_conditioner

Conditions up to 32 raw interrupt source lines into the `int_triggers` vector consumed by the SoC controller. It sits directly upstream of the SoC controller. Per line, it applies polarity correction, optional metastability synchronisation and optional debouncing. Each line then drives its trigger either as a level or as a single-cycle edge pulse, so that external pins and internal peripheral events reach the interrupt controller in a clean, registered form.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for lines selected by `SYNC_MASK`; legal range 2..4.
- `DEBOUNCE_CYCLES`, 4: number of consecutive differing samples needed to accept a new level; legal range 1..65535; 1 = no filtering.
- `SYNC_MASK`, 32'h0: bit i = 1 routes line i through the synchroniser (asynchronous/external sources); 0 = source is already synchronous to `clk`.
- `DEBOUNCE_MASK`, 32'h0: bit i = 1 applies debouncing to line i.
- `INVERT_MASK`, 32'h0: bit i = 1 means source i is active-low; it is inverted before any other processing.
- `EDGE_MASK`, 32'h0: bit i = 1 makes line i edge-triggered (single pulse); 0 = level-triggered.
- `FALL_MASK`, 32'h0: for edge lines, bit i = 1 selects the falling edge of the active-high signal; ignored for level lines.

Ports:
- `clk` in 1: system clock.
- `res` in 1: reset, asynchronous, active-high; all internal flops and outputs are cleared.
- `int_sources` in 32: raw interrupt sources.
- `int_triggers` out 32: registered trigger vector to the SoC controller.
- `line_state` out 32: accepted (post-debounce, active-high) level of each line, for debug/status.

## Operation
- Stage 1, polarity: `a[i] = int_sources[i] ^ INVERT_MASK[i]`, combinational.
- Stage 2, sync:
  - SYNC lines pass `a[i]` through a `SYNC_STAGES`-deep flop chain (reset 0).
  - Other lines pass `a[i]` through with no delay.
  - The result is `s[i]`.
- Stage 3, accepted level `stable[i]` (one register per line, reset 0):
  - Non-debounced lines: `stable[i] <= s[i]` every cycle.
  - Debounced lines keep a counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0.
  - If `s[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - Any glitch back to `stable[i]` restarts the count. The counter never wraps.
- Stage 4, history: `prev[i] <= stable[i]` every cycle (reset 0).
- Stage 5, output register:
  - Level line: `int_triggers[i] <= stable[i]`.
  - Edge line, rising: `int_triggers[i] <= stable[i] & ~prev[i]`.
  - Edge line, falling: `int_triggers[i] <= ~stable[i] & prev[i]`.
- `line_state = stable`, combinational from the register.
- All 32 lines are independent; simultaneous events on any number of lines are processed in parallel with no priority or loss.

## Timing
- Reset values: `int_triggers` = 0, `line_state` = 0, all sync/cnt/prev flops = 0.
- Latency is measured from the first clock edge that samples a new `a[i]` value (edge k) to the first cycle that value is visible on `int_triggers`:
  - Base: `stable` updates at edge k; `int_triggers` updates at edge k+1 (1 cycle after `stable`).
  - Sync adds `SYNC_STAGES` cycles.
  - Debounce adds `DEBOUNCE_CYCLES-1` cycles, provided `s` is held constant.
- Edge pulse width is exactly 1 cycle per accepted transition. Back-to-back accepted transitions (non-debounced line toggling every cycle) produce a pulse on every matching edge; none are merged.
- Level line output follows `stable` with 1 cycle delay. It stays high as long as the source is active, so the downstream controller re-flags after a clear while the source is still active.
- Reset release with a source already active (post-polarity):
  - `stable` rises after the normal latency.
  - A rising-edge line emits exactly one pulse.
  - A falling-edge line emits nothing.
- Reset asserted mid-debounce or mid-pulse clears everything immediately and asynchronously. No pulse is emitted on reset entry.

## Test plan
- Line 0, level, no sync/debounce: `int_sources[0]` 0→1 sampled at edge 10 → `line_state[0]=1` after edge 10, `int_triggers[0]=1` after edge 11, drops 1 cycle after the source falls.
- Line 1 in `EDGE_MASK` + `SYNC_MASK` (`SYNC_STAGES`=2): source held high from edge 5 → single 1-cycle pulse on `int_triggers[1]` after edge 8, then 0 while the source remains high.
- Line 2 in `DEBOUNCE_MASK` (`DEBOUNCE_CYCLES`=4):
  - 3-cycle high glitch → `line_state[2]` and `int_triggers[2]` stay 0.
  - Then a 4-cycle high → `line_state[2]=1` after the 4th sample, trigger 1 cycle later.
- Line 3 with `INVERT_MASK`, `EDGE_MASK` and `FALL_MASK` set: source 1→0 gives no pulse; source 0→1 (active level falling) gives exactly one pulse.
- Lines 4–31, all edge-rising: all 28 lines rise in the same cycle → all 28 `int_triggers` bits pulse in the same cycle; toggling line 4 every cycle yields a pulse every 2 cycles.
- Assert `res` during the debounce count on line 2 and while line 0 is high → all outputs 0 immediately. Release `res` with line 1 source high → exactly one edge pulse after the sync latency.

Source files
------------

// File: rtl/soc_int_trigger_conditioner.sv
// soc_int_trigger_conditioner
// Cleans up to 32 raw interrupt sources into a registered trigger vector.
// Each line gets polarity correction and an optional synchroniser.
// It then gets an optional debounce filter and is presented as a level or a
// single-cycle edge pulse.
module soc_int_trigger_conditioner #(
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 4,
  parameter logic        [31:0]   SYNC_MASK       = 32'h0,
  parameter logic        [31:0]   DEBOUNCE_MASK   = 32'h0,
  parameter logic        [31:0]   INVERT_MASK     = 32'h0,
  parameter logic        [31:0]   EDGE_MASK       = 32'h0,
  parameter logic        [31:0]   FALL_MASK       = 32'h0
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] int_sources,
  output logic [31:0] int_triggers,
  output logic [31:0] line_state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0] a_p0;       // active-high sources after polarity correction
  logic [31:0] s_p0;       // sources aligned to clk (synchronised where needed)
  logic [31:0] stable_p1;  // accepted level per line
  logic [31:0] prev_p2;    // accepted level one cycle earlier
  logic [31:0] trig_nxt;

  assign a_p0 = int_sources ^ INVERT_MASK;

  for (genvar i = 0; i < 32; i++) begin : g_line
    logic stable_q;

    // ---- sync stage: async lines get a flop chain, sync lines pass straight
    if (SYNC_MASK[i]) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;

      // Shift the polarity-corrected source through the synchroniser chain
      always_ff @(posedge clk or posedge res) begin
        if (res) chain_q <= '0;
        else     chain_q <= {chain_q[SYNC_STAGES-2:0], a_p0[i]};
      end

      assign s_p0[i] = chain_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s_p0[i] = a_p0[i];
    end

    // ---- accept stage: optional debounce filter feeding stable_p1
    if (DEBOUNCE_MASK[i]) begin : g_deb
      logic [CNT_W-1:0] cnt_q;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
      always_ff @(posedge clk or posedge res) begin
        if (res) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else if (s_p0[i] == stable_q) begin
          cnt_q    <= '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_q <= s_p0[i];
          cnt_q    <= '0;
        end else begin
          cnt_q    <= cnt_q + CNT_W'(1);
        end
      end
    end else begin : g_nodeb
      // Without filtering the accepted level simply follows the sample
      always_ff @(posedge clk or posedge res) begin
        if (res) stable_q <= 1'b0;
        else     stable_q <= s_p0[i];
      end
    end

    assign stable_p1[i] = stable_q;
  end

  // ---- output stage: level lines copy stable, edge lines compare with history
  // Select level, rising-edge or falling-edge behaviour per line
  always_comb begin
    trig_nxt = (~EDGE_MASK & stable_p1)
             | ( EDGE_MASK & ~FALL_MASK &  stable_p1 & ~prev_p2)
             | ( EDGE_MASK &  FALL_MASK & ~stable_p1 &  prev_p2);
  end

  // Register the history and the trigger vector
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      prev_p2      <= '0;
      int_triggers <= '0;
    end else begin
      prev_p2      <= stable_p1;
      int_triggers <= trig_nxt;
    end
  end

  assign line_state = stable_p1;

endmodule

// File: tb/tb_soc_int_trigger_conditioner.sv
// Testbench for soc_int_trigger_conditioner: directed scenarios plus random
// traffic, compared every cycle against a behavioural line model.
module tb_soc_int_trigger_conditioner;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam logic [31:0] SYNC_MASK       = 32'h0000_0002;
  localparam logic [31:0] DEBOUNCE_MASK   = 32'h0000_0004;
  localparam logic [31:0] INVERT_MASK     = 32'h0000_0008;
  localparam logic [31:0] EDGE_MASK       = 32'hFFFF_FFFA;
  localparam logic [31:0] FALL_MASK       = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] int_sources;
  logic [31:0] int_triggers;
  logic [31:0] line_state;

  int errors = 0;
  int checks = 0;
  int p1_cnt = 0;

  // Reference model state
  logic [31:0] m_stable, m_prev, m_trig;
  int          m_run [32];
  logic [31:0] m_q [$];

  soc_int_trigger_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_MASK      (SYNC_MASK),
    .DEBOUNCE_MASK  (DEBOUNCE_MASK),
    .INVERT_MASK    (INVERT_MASK),
    .EDGE_MASK      (EDGE_MASK),
    .FALL_MASK      (FALL_MASK)
  ) dut (
    .clk         (clk),
    .res         (res),
    .int_sources (int_sources),
    .int_triggers(int_triggers),
    .line_state  (line_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_prev   = '0;
    m_trig   = '0;
    for (int i = 0; i < 32; i++) m_run[i] = 0;
    m_q.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_q.push_back(32'h0);
  endtask

  // One clock of the line behaviour: the sample seen by the accept stage is
  // the current source for plain lines, or the source from SYNC_STAGES edges
  // ago for synchronised lines.
  task automatic model_edge(input logic [31:0] src);
    logic [31:0] a, s, delayed, old_st, old_pv, new_st;
    a       = src ^ INVERT_MASK;
    delayed = m_q.pop_front();
    m_q.push_back(a);
    s       = (SYNC_MASK & delayed) | (~SYNC_MASK & a);
    old_st  = m_stable;
    old_pv  = m_prev;
    new_st  = old_st;
    for (int i = 0; i < 32; i++) begin
      if (DEBOUNCE_MASK[i]) begin
        if (s[i] != old_st[i]) begin
          m_run[i]++;
          if (m_run[i] >= int'(DEBOUNCE_CYCLES)) begin
            new_st[i] = s[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end else begin
        new_st[i] = s[i];
      end
      if (!EDGE_MASK[i])     m_trig[i] = old_st[i];
      else if (FALL_MASK[i]) m_trig[i] = !old_st[i] && old_pv[i];
      else                   m_trig[i] = old_st[i] && !old_pv[i];
    end
    m_prev   = old_st;
    m_stable = new_st;
  endtask

  // Drive one source vector, clock it, and compare both outputs to the model
  task automatic cycle(input logic [31:0] src);
    int_sources = src;
    @(posedge clk);
    if (!res) model_edge(src);
    @(negedge clk);
    chk("int_triggers", int_triggers, m_trig);
    chk("line_state", line_state, m_stable);
    if (int_triggers[1]) p1_cnt++;
  endtask

  initial begin
    logic [31:0] src;
    res         = 1'b1;
    int_sources = 32'h0;
    model_reset();
    repeat (3) cycle(32'h0);
    chk("reset_triggers", int_triggers, 32'h0);
    chk("reset_state", line_state, 32'h0);
    res = 1'b0;
    repeat (4) cycle(32'h0);

    // Line 0: level, no sync/debounce
    cycle(32'h1);
    chk("l0_state_rise", {31'b0, line_state[0]}, 32'h1);
    chk("l0_trig_lag", {31'b0, int_triggers[0]}, 32'h0);
    cycle(32'h1);
    chk("l0_trig_rise", {31'b0, int_triggers[0]}, 32'h1);
    cycle(32'h0);
    chk("l0_trig_hold", {31'b0, int_triggers[0]}, 32'h1);
    cycle(32'h0);
    chk("l0_trig_fall", {31'b0, int_triggers[0]}, 32'h0);

    // Line 1: synchronised rising edge, held high
    p1_cnt = 0;
    repeat (3) cycle(32'h2);
    chk("l1_no_early_pulse", {31'b0, int_triggers[1]}, 32'h0);
    cycle(32'h2);
    chk("l1_pulse", {31'b0, int_triggers[1]}, 32'h1);
    repeat (5) cycle(32'h2);
    chk("l1_single_pulse", p1_cnt, 32'd1);
    repeat (4) cycle(32'h0);

    // Line 2: debounced; a 3-cycle glitch is rejected, a 4-cycle level accepted
    repeat (3) cycle(32'h4);
    cycle(32'h0);
    chk("l2_glitch_state", {31'b0, line_state[2]}, 32'h0);
    chk("l2_glitch_trig", {31'b0, int_triggers[2]}, 32'h0);
    repeat (3) cycle(32'h4);
    chk("l2_not_yet", {31'b0, line_state[2]}, 32'h0);
    cycle(32'h4);
    chk("l2_accepted", {31'b0, line_state[2]}, 32'h1);
    cycle(32'h4);
    chk("l2_trig", {31'b0, int_triggers[2]}, 32'h1);
    repeat (6) cycle(32'h0);

    // Line 3: active-low, falling edge of the active level
    cycle(32'h8);
    cycle(32'h8);
    chk("l3_pulse", {31'b0, int_triggers[3]}, 32'h1);
    cycle(32'h8);
    chk("l3_pulse_width", {31'b0, int_triggers[3]}, 32'h0);
    cycle(32'h0);
    cycle(32'h0);
    chk("l3_no_pulse_on_rise", {31'b0, int_triggers[3]}, 32'h0);

    // Lines 4..31 rise together
    cycle(32'hFFFF_FFF0);
    cycle(32'hFFFF_FFF0);
    chk("bulk_pulse", {4'b0, int_triggers[31:4]}, 32'h0FFF_FFFF);
    cycle(32'hFFFF_FFF0);
    chk("bulk_pulse_end", {4'b0, int_triggers[31:4]}, 32'h0);
    repeat (2) cycle(32'h0);

    // Line 4 toggling every cycle
    for (int k = 0; k < 10; k++) cycle((k % 2 == 0) ? 32'h10 : 32'h0);
    repeat (2) cycle(32'h0);

    // Random traffic with slowly changing bits to exercise the debouncer
    src = 32'h0;
    for (int k = 0; k < 400; k++) begin
      src = src ^ ($urandom() & $urandom() & $urandom());
      if ((k % 50) < 10) src[2] = $urandom_range(0, 1);
      cycle(src);
    end
    repeat (4) cycle(32'h0);

    // Reset in the middle of a debounce count on line 2 while line 0 is high
    cycle(32'h5);
    cycle(32'h5);
    cycle(32'h5);
    res = 1'b1;
    #1;
    chk("async_reset_triggers", int_triggers, 32'h0);
    chk("async_reset_state", line_state, 32'h0);
    model_reset();
    repeat (2) cycle(32'h2);
    res    = 1'b0;
    p1_cnt = 0;
    repeat (10) cycle(32'h2);
    chk("release_l1_one_pulse", p1_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
